// File: rtl/sccb_init_seq.sv
// Table-driven SCCB register initialiser: walks a ROM of {reg, value} entries,
// issuing bridge writes, optional read-back compares and in-table delays.
module sccb_init_seq #(
   parameter int          ROM_AW    = 8,
   parameter logic [6:0]  DEV_ID    = 7'h21,
   parameter bit          VERIFY    = 1'b1,
   parameter int          DLY_SHIFT = 10,
   parameter logic [19:0] TO_CYCLES = 20'd1000000
) (
   input  logic              sccb_clk,
   input  logic              sccb_reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [7:0]        mismatch_cnt,
   output logic [7:0]        last_rdata,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic [2:0]        mcmd,
   output logic [14:0]       maddr,
   output logic [7:0]        mdata,
   input  logic              scmdaccept,
   input  logic [1:0]        sresp,
   input  logic [7:0]        sdata
);

   localparam int DW = 8 + DLY_SHIFT;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_WR_REQ, S_WR_WAIT,
      S_RD_REQ, S_RD_WAIT, S_DELAY, S_DONE, S_ERR
   } state_e;

   state_e            state_q, state_d;
   logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
   logic [14:0]       maddr_q, maddr_d;
   logic [7:0]        mdata_q, mdata_d;
   logic [2:0]        mcmd_q, mcmd_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [7:0]        mm_q, mm_d;
   logic [7:0]        last_q, last_d;
   logic              cap_q, cap_d;
   logic [19:0]       to_cnt_q, to_cnt_d;
   logic [DW-1:0]     dly_q, dly_d;
   logic              to_hit, adv;

   always_ff @(posedge sccb_clk) begin
      if (sccb_reset) begin
         state_q    <= S_IDLE;
         rom_addr_q <= '0;
         maddr_q    <= '0;
         mdata_q    <= '0;
         mcmd_q     <= 3'b000;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
         mm_q       <= '0;
         last_q     <= '0;
         cap_q      <= 1'b0;
         to_cnt_q   <= '0;
         dly_q      <= '0;
      end else begin
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         maddr_q    <= maddr_d;
         mdata_q    <= mdata_d;
         mcmd_q     <= mcmd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         mm_q       <= mm_d;
         last_q     <= last_d;
         cap_q      <= cap_d;
         to_cnt_q   <= to_cnt_d;
         dly_q      <= dly_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rom_addr_d = rom_addr_q;
      maddr_d    = maddr_q;
      mdata_d    = mdata_q;
      err_code_d = err_code_q;
      mm_d       = mm_q;
      last_d     = last_q;
      cap_d      = cap_q;
      dly_d      = dly_q;
      to_cnt_d   = to_cnt_q + 20'd1;
      to_hit     = (to_cnt_q == TO_CYCLES - 20'd1);
      adv        = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d    = S_FETCH;
               rom_addr_d = '0;
               err_code_d = 2'b00;
               mm_d       = '0;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            maddr_d = {DEV_ID, rom_data[15:8]};
            mdata_d = rom_data[7:0];
            if (rom_data == 16'hFFFF) begin
               state_d = S_DONE;
            end else if (rom_data[15:8] == 8'hFE) begin
               if (rom_data[7:0] == 8'h00) begin
                  adv = 1'b1;
               end else begin
                  // counts down to 0 inclusive, so preload one less than the length
                  dly_d   = (DW'(rom_data[7:0]) << DLY_SHIFT) - DW'(1);
                  state_d = S_DELAY;
               end
            end else begin
               state_d = S_WR_REQ;
            end
         end
         S_WR_REQ: begin
            if (!scmdaccept) state_d = S_WR_WAIT;
            else if (to_hit) begin
               state_d    = S_ERR;
               err_code_d = 2'b01;
            end
         end
         S_WR_WAIT: begin
            if (scmdaccept) begin
               if (VERIFY) state_d = S_RD_REQ;
               else adv = 1'b1;
            end else if (to_hit) begin
               state_d    = S_ERR;
               err_code_d = 2'b10;
            end
         end
         S_RD_REQ: begin
            if (!scmdaccept) state_d = S_RD_WAIT;
            else if (to_hit) begin
               state_d    = S_ERR;
               err_code_d = 2'b01;
            end
         end
         S_RD_WAIT: begin
            // the bridge holds DVA for a whole divider period; only the first beat counts
            if (sresp == 2'b01 && !cap_q) begin
               cap_d  = 1'b1;
               last_d = sdata;
               if (sdata != mdata_q && mm_q != 8'hFF) mm_d = mm_q + 8'd1;
            end
            if (scmdaccept && (cap_q || sresp == 2'b01)) adv = 1'b1;
            else if (to_hit) begin
               state_d    = S_ERR;
               err_code_d = 2'b10;
            end
         end
         S_DELAY: begin
            if (dly_q == '0) adv = 1'b1;
            else dly_d = dly_q - DW'(1);
         end
         default: state_d = S_IDLE;
      endcase
      if (adv) begin
         if (rom_addr_q == '1) begin
            state_d    = S_ERR;
            err_code_d = 2'b11;
         end else begin
            rom_addr_d = rom_addr_q + ROM_AW'(1);
            state_d    = S_FETCH;
         end
      end
      if (state_d != state_q) to_cnt_d = '0;
      if (state_d == S_RD_WAIT && state_q != S_RD_WAIT) cap_d = 1'b0;
   end

   always_comb begin
      mcmd_d = 3'b000;
      if (state_d == S_WR_REQ) mcmd_d = 3'b001;
      else if (state_d == S_RD_REQ) mcmd_d = 3'b010;
      busy_d = !(state_d inside {S_IDLE, S_DONE, S_ERR});
      done_d = (state_d == S_DONE);
      err_d  = (state_d == S_ERR);
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign err_code     = err_code_q;
   assign mismatch_cnt = mm_q;
   assign last_rdata   = last_q;
   assign rom_addr     = rom_addr_q;
   assign mcmd         = mcmd_q;
   assign maddr        = maddr_q;
   assign mdata        = mdata_q;

endmodule

// File: doc/sccb_init_seq.md
# sccb_init_seq

Table-driven camera register initialiser that sits directly upstream of the SCCB bridge and drives its bus interface. On `start`, it walks a register table held in an external synchronous ROM. For each entry it issues a write command to the bridge, can optionally read the register back and compare it, and supports in-table delays. It reports completion, errors and the number of read-back mismatches to the host or debug logic.

## Interface
Parameters:
- ROM_AW, 8, ROM address width; the table holds at most 2^ROM_AW entries.
- DEV_ID, 7'h21, 7-bit SCCB device ID driven on maddr[14:8].
- VERIFY, 1, when 1 every register write is followed by a read-back and compare.
- DLY_SHIFT, 10, delay entry unit: one unit is 2^DLY_SHIFT clocks.
- TO_CYCLES, 20'd1000000, handshake timeout in clocks; the timeout counter is 20 bits wide.

Ports:
- sccb_clk  in  1  single clock, shared with the bridge.
- sccb_reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a table walk.
- busy  out  1  high from the cycle after `start` is accepted until DONE or ERR.
- done  out  1  level; table completed without error.
- err  out  1  level; walk aborted.
- err_code  out  2  01 = accept timeout, 10 = completion timeout, 11 = no end marker found.
- mismatch_cnt  out  8  read-back mismatches seen; saturates at 255.
- last_rdata  out  8  last byte read back.
- rom_addr  out  ROM_AW  table address.
- rom_data  in  16  {reg_addr[15:8], value[7:0]}; valid one clock after rom_addr changes.
- mcmd  out  3  000 idle, 001 write, 010 read.
- maddr  out  15  {DEV_ID, reg_addr}.
- mdata  out  8  write value.
- scmdaccept  in  1  bridge idle / ready.
- sresp  in  2  01 = data valid (DVA).
- sdata  in  8  read data.

## Operation
- Table entry decode:
  - 16'hFFFF marks end of table.
  - {8'hFE, n} is a delay of n × 2^DLY_SHIFT clocks; n = 0 means no delay.
  - Any other value is a register write.
- States: IDLE, FETCH, DECODE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DELAY, DONE, ERR.
- IDLE, DONE, ERR: on `start`:
  - clear done, err, err_code and mismatch_cnt;
  - set rom_addr = 0;
  - go to FETCH.
- `start` is ignored in every other state.
- FETCH: takes one cycle, then goes to DECODE.
- DECODE: samples rom_data and registers maddr and mdata.
  - End marker goes to DONE.
  - Delay entry loads the delay counter and goes to DELAY.
  - Any other entry goes to WR_REQ.
- WR_REQ: mcmd = 001, held until scmdaccept is sampled 0.
  - mcmd = 000 from the next cycle, in WR_WAIT.
- WR_WAIT: wait for scmdaccept = 1.
  - If VERIFY = 1, go to RD_REQ; otherwise ADVANCE.
- RD_REQ: mcmd = 010, held until scmdaccept is sampled 0, then go to RD_WAIT.
- RD_WAIT:
  - On the first sample of sresp = 01, capture sdata into last_rdata.
  - If sdata ≠ mdata, increment mismatch_cnt (saturating).
  - Later cycles of sresp = 01 are ignored, because the bridge holds sresp for a whole divider period.
  - Leave RD_WAIT when scmdaccept = 1 and the capture has happened; then ADVANCE.
- DELAY: count down to 0, then ADVANCE.
- ADVANCE:
  - If rom_addr == 2^ROM_AW−1, go to ERR with err_code 11.
  - Otherwise rom_addr + 1 and go to FETCH.
- Timeout: the counter clears on entry to each REQ or WAIT state.
  - Reaching TO_CYCLES in a REQ state goes to ERR with err_code 01.
  - Reaching TO_CYCLES in a WAIT state goes to ERR with err_code 10.
- mcmd is forced to 000 in every state except WR_REQ and RD_REQ.
- A read-back mismatch never aborts the walk.

## Timing
- Reset values: mcmd = 0, maddr = 0, mdata = 0, rom_addr = 0, busy = 0, done = 0, err = 0, err_code = 0, mismatch_cnt = 0, last_rdata = 0; state = IDLE.
- Reset mid-walk: mcmd returns to 000 on the next edge. The bridge may finish its current transfer on its own; the sequencer ignores it.
- All outputs are registered.
- `start` sampled at edge N: busy = 1 and rom_addr = 0 from N+1; DECODE occurs at N+2.
- ROM read latency is exactly 1 clock.
- Each write costs at least 3 clocks plus the bridge transfer time.
- Consecutive commands are separated by at least 1 idle mcmd cycle, so the bridge never re-captures a stale command.
- done or err rises in the same cycle that busy falls. Both hold until the next accepted `start` or reset.

## Test plan
- Table {1234, 12AB, FFFF}, VERIFY = 0, bridge model with divider 4 → two writes seen: maddr 0x2112 with mdata 0x34, then mdata 0xAB; done = 1, err = 0, rom_addr final = 2.
- Same table, VERIFY = 1, model returns 0x34 then 0x00 → read mcmd 010 after each write; mismatch_cnt = 1; last_rdata = 0x00; done = 1.
- Table {FE03, 1055, FFFF}, DLY_SHIFT = 2 → exactly 12 delay clocks before the write mcmd = 001 asserts.
- Model holds scmdaccept = 1 forever (never accepts), TO_CYCLES = 50 → err = 1, err_code = 01 after 50 clocks in WR_REQ; mcmd = 000 afterwards.
- ROM_AW = 2, table with no FFFF entry → err_code = 11 after the 4th entry; additionally, a `start` pulsed mid-walk is ignored and sccb_reset mid-write gives mcmd = 000 on the next edge.
